// File: rtl/serial_addsub_8bit_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding,
// default operand width and a helper that sizes the bit counter.
package addsub_pkg;

  localparam int DEFAULT_NUM_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of a counter that must reach n-1; never narrower than one bit so a
  // degenerate single-bit configuration still elaborates.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_8bit_adder_1bit.sv
// Single-bit full adder used as the arithmetic slice of the serial unit.
// Purely combinational; the surrounding registers provide the sequencing.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  // Classic sum/majority equations for one bit position.
  always_comb begin
    sum       = a ^ b ^ carry_in;
    carry_out = (a & b) | (a & carry_in) | (b & carry_in);
  end

endmodule

// File: rtl/serial_addsub_8bit.sv
// Bit-serial NUM_BITS-wide adder/subtractor. One result bit is produced per
// clock, LSB first, under a start/busy/done handshake. Subtraction is done as
// a + ~b + ~carry_in, and the final carry is inverted so overflow reads as a
// borrow. All outputs come straight from flops.
module serial_addsub_8bit
  import addsub_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                subtract,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = cntWidth(NUM_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

  state_e              state_q;
  logic [NUM_BITS-1:0] aShift_q;
  logic [NUM_BITS-1:0] bShift_q;
  logic [NUM_BITS-1:0] partSum_q;
  logic [NUM_BITS-1:0] sum_q;
  logic [CNT_W-1:0]    bitCnt_q;
  logic                carry_q;
  logic                sub_q;
  logic                overflow_q;
  logic                busy_q;
  logic                done_q;

  logic                sumBit_d;
  logic                carry_d;
  logic [NUM_BITS-1:0] partSum_d;

  // The one arithmetic slice: LSBs of the operand shifters plus the carry flop.
  adder_1bit u_slice (
    .a         (aShift_q[0]),
    .b         (bShift_q[0]),
    .carry_in  (carry_q),
    .sum       (sumBit_d),
    .carry_out (carry_d)
  );

  // Next partial sum: the fresh bit enters at the MSB, so after NUM_BITS
  // shifts the LSB-first stream sits in natural bit order.
  generate
    if (NUM_BITS > 1) begin : gen_wide
      assign partSum_d = {sumBit_d, partSum_q[NUM_BITS-1:1]};
    end else begin : gen_narrow
      assign partSum_d = sumBit_d;
    end
  endgenerate

  // Control FSM and datapath registers. A new operation is accepted from
  // IDLE or DONE only; start during SHIFT is ignored so the operand registers
  // stay private to the running computation. sum/overflow change only on the
  // final SHIFT cycle, so they never expose a partial result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      partSum_q  <= '0;
      sum_q      <= '0;
      bitCnt_q   <= '0;
      carry_q    <= 1'b0;
      sub_q      <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            aShift_q  <= a;
            bShift_q  <= subtract ? ~b : b;
            carry_q   <= carry_in ^ subtract;
            sub_q     <= subtract;
            bitCnt_q  <= '0;
            partSum_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        SHIFT: begin
          aShift_q  <= aShift_q >> 1;
          bShift_q  <= bShift_q >> 1;
          carry_q   <= carry_d;
          partSum_q <= partSum_d;
          bitCnt_q  <= bitCnt_q + CNT_W'(1);
          if (bitCnt_q == LAST_CNT) begin
            sum_q      <= partSum_d;
            overflow_q <= carry_d ^ sub_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sum      = sum_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
